load_store_unit: RTL and testbench

Load/store unit sitting between the single-cycle MIPS datapath and the 128 x 32-bit word-addressed data memory, acting as the initiator on the memory's write-enable/address/data interface. Accepts byte, halfword and word loads/stores at byte addresses and converts them into word-wide memory accesses. Loads are sign- or zero-extended. Sub-word stores are performed as a read-modify-write sequence. Misaligned accesses are rejected.

---
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-addressed memory; sub-word stores use read-modify-write.
// Latency: load/word store/error 1 cycle, sub-word store 2 cycles; requests are ignored while o_ready=0.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_misaligned,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_write_data,
  input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, ERR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wbuf_q;

  logic                  misaligned_in;
  logic [DATA_WIDTH-1:0] byte_shift;
  logic [DATA_WIDTH-1:0] half_shift;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] merge_val;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] lane_data;

  // Size 2'b11 shares the word alignment rule through i_size[1].
  assign misaligned_in = ((i_size == 2'b01) && i_addr[0]) ||
                         (i_size[1] && (i_addr[1:0] != 2'b00));

  assign byte_shift = i_mem_read_data >> {addr_q[1:0], 3'b000};
  assign half_shift = i_mem_read_data >> {addr_q[1], 4'b0000};
  assign byte_v     = byte_shift[7:0];
  assign half_v     = half_shift[15:0];

  always_comb begin
    load_val  = i_mem_read_data;
    lane_mask = '1;
    lane_data = wdata_q;
    case (size_q)
      2'b00: begin
        load_val  = {{24{signed_q & byte_v[7]}}, byte_v};
        lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        lane_data = (wdata_q & 32'h0000_00FF) << {addr_q[1:0], 3'b000};
      end
      2'b01: begin
        load_val  = {{16{signed_q & half_v[15]}}, half_v};
        lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
        lane_data = (wdata_q & 32'h0000_FFFF) << {addr_q[1], 4'b0000};
      end
      default: ;
    endcase
    merge_val = (i_mem_read_data & ~lane_mask) | lane_data;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wbuf_q       <= '0;
      o_rdata      <= '0;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            addr_q   <= i_addr;
            size_q   <= i_size;
            signed_q <= i_signed;
            we_q     <= i_we;
            wdata_q  <= i_wdata;
            if (misaligned_in) begin
              state <= ERR;
            end else if (!i_we) begin
              state <= LOAD;
            end else if (i_size[1]) begin
              wbuf_q <= i_wdata;
              state  <= WRITE;
            end else begin
              state <= MERGE;
            end
          end
        end
        LOAD: begin
          o_rdata <= load_val;
          o_valid <= 1'b1;
          state   <= IDLE;
        end
        MERGE: begin
          wbuf_q <= merge_val;
          state  <= WRITE;
        end
        WRITE: begin
          o_valid <= 1'b1;
          state   <= IDLE;
        end
        ERR: begin
          o_valid      <= 1'b1;
          o_misaligned <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write enable decodes the state register directly so reset kills it without an edge.
  assign o_ready          = (state == IDLE);
  assign o_mem_we         = (state == WRITE);
  assign o_mem_address    = {2'b00, addr_q[ADDR_WIDTH-1:2]};
  assign o_mem_write_data = wbuf_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests, expected completions queued and checked by a monitor.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_arst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic        i_signed = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_ready, o_valid, o_misaligned, o_mem_we;
  logic [31:0] o_rdata, o_mem_address, o_mem_write_data, i_mem_read_data;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_signed(i_signed), .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready),
    .o_valid(o_valid), .o_rdata(o_rdata), .o_misaligned(o_misaligned), .o_mem_we(o_mem_we),
    .o_mem_address(o_mem_address), .o_mem_write_data(o_mem_write_data),
    .i_mem_read_data(i_mem_read_data)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] mem [0:127];
  assign i_mem_read_data = (o_mem_address < 32'd128) ? mem[o_mem_address[6:0]] : 32'h0;
  always @(posedge i_clk)
    if (o_mem_we && o_mem_address < 32'd128) mem[o_mem_address[6:0]] = o_mem_write_data;

  typedef struct {
    logic        mis;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_cnt = 0;
  int we_cyc = -1;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (o_mem_we) begin
      we_cnt++;
      we_cyc = cyc;
    end
    if (o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("misaligned_flag", {31'd0, o_misaligned}, {31'd0, e.mis});
        chk("rdata", o_rdata, e.rdata);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic push,
                       input logic mis, input logic [31:0] rdata, input int lat, output int acc);
    int n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) chk("ready_timeout", 32'd0, 32'd1);
    i_req = 1'b1; i_we = we; i_size = size; i_signed = sgn; i_addr = addr; i_wdata = wdata;
    @(posedge i_clk);
    #1;
    acc = cyc;
    i_req = 1'b0;
    if (push) sb.push_back('{mis, rdata, acc + lat});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("completion_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge i_clk);
  endtask

  initial begin
    int a0, a1, w0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[1] = 32'h8899_AABB;
    #12;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_misaligned", {31'd0, o_misaligned}, 32'd0);
    chk("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_mem_address", o_mem_address, 32'h0);
    chk("rst_mem_write_data", o_mem_write_data, 32'h0);
    i_arst_n = 1'b1;

    // Byte loads from word 1
    issue(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFAA, 1, a0);
    issue(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 1'b1, 1'b0, 32'h0000_00AA, 1, a0);
    drain();

    // Halfword store into upper half of word 1
    w0 = we_cnt;
    issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_00AA, 2, a0);
    drain();
    chk("hstore_mem", mem[1], 32'h1234_AABB);
    chk("hstore_we_count", we_cnt - w0, 32'd1);
    chk("hstore_we_cycle", we_cyc, a0 + 1);

    // Word store then word load accepted on the completion edge
    issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_00AA, 1, a0);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1, a1);
    drain();
    chk("wstore_mem", mem[2], 32'hDEAD_BEEF);
    chk("back_to_back_gap", a1 - a0, 32'd2);

    // Misaligned load and store
    w0 = we_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1, a0);
    issue(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_5555, 1'b1, 1'b1, 32'hDEAD_BEEF, 1, a0);
    issue(1'b0, 2'b11, 1'b0, 32'h1, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1, a0);
    drain();
    chk("misaligned_no_we", we_cnt - w0, 32'd0);
    chk("misaligned_mem0", mem[0], 32'h0);
    chk("misaligned_mem1", mem[1], 32'h1234_AABB);

    // Request pulsed during MERGE must be dropped
    issue(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0077, 1'b1, 1'b0, 32'hDEAD_BEEF, 2, a0);
    i_req = 1'b1; i_we = 1'b1; i_size = 2'b10; i_addr = 32'h10; i_wdata = 32'hFFFF_FFFF;
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    drain();
    chk("busy_store_mem", mem[2], 32'hDEAD_77EF);
    chk("busy_ignored_mem", mem[4], 32'h0);

    // Extension of sub-word loads from the merged word
    issue(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 1'b1, 1'b0, 32'hFFFF_DEAD, 1, a0);
    issue(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'h0000_77EF, 1, a0);
    issue(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 1'b1, 1'b0, 32'h0000_00DE, 1, a0);
    issue(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 1'b1, 1'b0, 32'h0000_0077, 1, a0);
    drain();

    // Reset during the WRITE cycle of a byte store
    issue(1'b1, 2'b00, 1'b0, 32'h4, 32'h0000_0055, 1'b0, 1'b0, 32'h0, 2, a0);
    @(posedge i_clk);
    #1;
    chk("pre_reset_we", {31'd0, o_mem_we}, 32'd1);
    i_arst_n = 1'b0;
    #1;
    chk("reset_we_drop", {31'd0, o_mem_we}, 32'd0);
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_arst_n = 1'b1;
    repeat (4) @(negedge i_clk);
    chk("post_reset_ready", {31'd0, o_ready}, 32'd1);
    chk("post_reset_rdata", o_rdata, 32'h0);
    chk("reset_mem_unchanged", mem[1], 32'h1234_AABB);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
